// File: rtl/prog_ctr_fsm.sv
// ---------------------------------------------------------------------------
// prog_ctr_fsm
//
// Program counter and fetch sequencer. Produces the instruction-memory
// address every cycle and owns the IDLE / RUN / HALT state of the processor.
// It takes the signed relative offset from the jump-target table and the
// decoder's branch controls.
//
// Optional feature macro: PC_LINK_EN
//   When defined, a single-level link register is enabled:
//     - A taken call stores prog_ctr + 1.
//     - ret jumps to the stored address.
//   When undefined, call and ret are ignored and link_addr is tied to 0.
//   The port list is the same in both builds.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   start      in   level; begins a program from IDLE or HALT
//   halt       in   current instruction is HALT
//   stall      in   hold PC and state this cycle
//   branch_rel in   relative jump instruction
//   branch_abs in   absolute jump instruction
//   cond       in   branch condition; a branch is taken only when cond=1
//   target     in   [D-1:0] two's-complement relative offset
//   abs_addr   in   [D-1:0] absolute jump destination
//   call       in   taken branch is a call (PC_LINK_EN only)
//   ret        in   return instruction (PC_LINK_EN only)
//   prog_ctr   out  [D-1:0] current fetch address (registered)
//   running    out  high in RUN (decoded from state)
//   done       out  high in HALT (decoded from state)
//   link_addr  out  [D-1:0] saved return address
//
// Handshake: start is a level. It is sampled on each rising Clk edge while
// the block is in IDLE or HALT, and ignored in RUN. done stays high for as
// long as the block is in HALT.
//
// Outputs depend only on registers. There is no combinational path from any
// input to any output.
// ---------------------------------------------------------------------------
module prog_ctr_fsm #(
    parameter int            D          = 12,
    parameter logic [D-1:0]  START_ADDR = '0
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic         halt,
    input  logic         stall,
    input  logic         branch_rel,
    input  logic         branch_abs,
    input  logic         cond,
    input  logic [D-1:0] target,
    input  logic [D-1:0] abs_addr,
    input  logic         call,
    input  logic         ret,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic [D-1:0] link_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

    logic [1:0]   state;
    logic [D-1:0] pc_inc;
    logic         abs_taken;
    logic         rel_taken;
    logic         ret_taken;
    logic [D-1:0] link_q;

    // All additions are D bits wide, so any carry out is dropped and the
    // address wraps modulo 2^D.
    assign pc_inc    = prog_ctr + ONE;
    assign abs_taken = branch_abs & cond;
    assign rel_taken = branch_rel & cond;

`ifdef PC_LINK_EN
    assign ret_taken = ret;
`else
    assign ret_taken = 1'b0;
    logic unused_link_inputs;
    assign unused_link_inputs = &{1'b0, call, ret, link_q};
`endif

    assign running = (state == RUN);
    assign done    = (state == HALT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            prog_ctr <= START_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        prog_ctr <= START_ADDR;
                    end
                end
                RUN: begin
                    // Priority order: stall, halt, ret, absolute branch,
                    // relative branch, then sequential fetch.
                    if (stall) begin
                        prog_ctr <= prog_ctr;
                    end else if (halt) begin
                        state <= HALT;
                    end else if (ret_taken) begin
                        prog_ctr <= link_q;
                    end else if (abs_taken) begin
                        prog_ctr <= abs_addr;
                    end else if (rel_taken) begin
                        prog_ctr <= prog_ctr + target;
                    end else begin
                        prog_ctr <= pc_inc;
                    end
                end
                HALT: begin
                    if (start) begin
                        state    <= RUN;
                        prog_ctr <= START_ADDR;
                    end
                end
                default: begin
                    state    <= IDLE;
                    prog_ctr <= START_ADDR;
                end
            endcase
        end
    end

`ifdef PC_LINK_EN
    // Single-level link register with no stack. A nested call overwrites it.
    // It is written only when the call's branch is actually taken. Cycles
    // lost to stall, halt or ret do not write it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            link_q <= '0;
        end else if (state == RUN && !stall && !halt && !ret_taken &&
                     (abs_taken || rel_taken) && call) begin
            link_q <= pc_inc;
        end
    end
    assign link_addr = link_q;
`else
    assign link_q    = '0;
    assign link_addr = '0;
`endif

endmodule

// File: doc/prog_ctr_fsm.md
Name: prog_ctr_fsm

Overview:
- Program counter and fetch-sequencing stage; sits directly downstream of the relative-jump target lookup table.
- Consumes the signed relative offset from that table and the decoder's branch controls, and produces the instruction-memory address every cycle.
- Owns the run/halt state of the processor and the start/done handshake with the testbench or top level.

Parameters:
- D, 12, PC and target width; address space is 2^D words.
- START_ADDR, 0, PC value after reset and on every start.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled in IDLE or HALT to begin a program.
- halt  input  1  decoder: current instruction is HALT.
- stall  input  1  hold PC this cycle.
- branch_rel  input  1  decoder: relative jump instruction.
- branch_abs  input  1  decoder: absolute jump instruction.
- cond  input  1  branch condition flag; a branch is taken only when cond=1.
- target  input  D  two's-complement relative offset from the lookup table.
- abs_addr  input  D  absolute jump destination.
- call  input  1  branch is a call (used only with PC_LINK_EN).
- ret  input  1  return instruction (used only with PC_LINK_EN).
- prog_ctr  output  D  current fetch address.
- running  output  1  high in RUN.
- done  output  1  high in HALT.
- link_addr  output  D  saved return address.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, prog_ctr=START_ADDR.
  - running=0, done=0, link_addr=0.
  - Applies immediately, including mid-RUN. Release is synchronous to the next Clk edge.
- States: IDLE, RUN, HALT, two-bit encoded. All outputs are registered or decoded from state only; no combinational input-to-output path.
- IDLE:
  - start=1 -> RUN next cycle, prog_ctr=START_ADDR.
  - Otherwise hold.
  - All other inputs are ignored.
- RUN: per cycle, in priority order:
  1. stall=1: hold prog_ctr and state. halt, branch and call inputs are ignored that cycle.
  2. halt=1: -> HALT, prog_ctr holds at the halt address.
  3. ret=1 (PC_LINK_EN only): prog_ctr <= link_addr.
  4. branch_abs & cond: prog_ctr <= abs_addr.
  5. branch_rel & cond: prog_ctr <= (prog_ctr + target) mod 2^D, i.e. D-bit add with carry discarded. target=all-ones yields prog_ctr-1.
  6. Otherwise prog_ctr <= prog_ctr + 1 mod 2^D. 2^D-1 wraps to 0.
- Simultaneous branch_abs and branch_rel: abs wins.
- Branch with cond=0: sequential increment.
- start is ignored while in RUN.
- HALT:
  - done=1, running=0, prog_ctr holds.
  - start=1 -> RUN next cycle with prog_ctr=START_ADDR; done drops in that same cycle.
- Latency: one cycle from control inputs to the new prog_ctr.
- No X propagation: target and abs_addr are don't-care when their enables are low.

Optional Feature:
- Macro: PC_LINK_EN.
- Defined:
  - A taken branch (abs or rel) with call=1 writes link_addr <= prog_ctr + 1 mod 2^D in the same cycle as the jump.
  - ret=1 in RUN with no stall jumps to link_addr at priority 3.
  - Single-level link register, no stack; a nested call overwrites it.
- Undefined:
  - call and ret are ignored; ret is treated as a normal sequential instruction.
  - link_addr is tied to 0.
  - Port list is identical in both builds.

Test Plan:
- Reset_n=0 then 1, start=1 for one cycle, 4 free-running cycles -> prog_ctr 0,1,2,3; running=1 from the cycle after start.
- At prog_ctr=10: branch_rel=1, cond=1, target=0xFFB (-5) -> prog_ctr=5. Repeat with cond=0 -> prog_ctr=11. target=0x014 (+20) from 5 -> 25.
- prog_ctr=0xFFF with no branch -> 0x000. prog_ctr=2 with target=0xFFD (-3) -> 0xFFF.
- branch_abs=1 and branch_rel=1 together, cond=1, abs_addr=0x100 -> prog_ctr=0x100.
- stall=1 together with halt=1 at prog_ctr=7 -> PC stays 7, state RUN. Next cycle halt=1 alone -> done=1, PC stays 7. start=1 -> PC=0, done=0, running=1.
- Reset_n pulsed low mid-RUN at prog_ctr=0x2A -> prog_ctr=0 and running=0 without a clock edge. With PC_LINK_EN: call+branch_abs at 0x20 to 0x80 -> link_addr=0x21; then ret -> prog_ctr=0x21.
